// File: rtl/dma_pkg.sv
// Shared types and register field positions for the multi-channel DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } dma_state_e;

  localparam logic [1:0] SEL_SRC  = 2'd0;
  localparam logic [1:0] SEL_DST  = 2'd1;
  localparam logic [1:0] SEL_LEN  = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BURST   = 1;
  localparam int CTRL_SRC_FIX = 2;
  localparam int CTRL_DST_FIX = 3;

  // Field order matches cfg_wdata[CTRL_DST_FIX:CTRL_BURST].
  typedef struct packed {
    logic dst_fix;
    logic src_fix;
    logic burst;
  } dma_ctrl_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel strictly after ptr.
module dma_rr_arbiter import dma_pkg::*; #(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt,
  output logic              gnt_vld
);

  logic [CH_W-1:0] idx;

  // Walk downward so the channel nearest after ptr is the last assignment and wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_multi_channel.sv
// Multi-channel memory-to-memory DMA: per-channel config, round-robin service,
// one shared bus moving one word per READ/WAIT/WRITE sequence.
module dma_multi_channel import dma_pkg::*; #(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 16,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [NUM_CH-1:0] ch_done,
  output logic              busy
);

  logic      [NUM_CH-1:0][ADDR_W-1:0] src_r, dst_r;
  logic      [NUM_CH-1:0][LEN_W-1:0]  len_r;
  dma_ctrl_t [NUM_CH-1:0]             ctrl_r;
  logic      [NUM_CH-1:0]             armed;

  dma_state_e        state, state_nxt;
  logic [CH_W-1:0]   cur_ch, rr_ptr, arb_gnt;
  logic              arb_vld;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_dec;

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (armed),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  assign len_dec = len_r[cur_ch] - LEN_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|armed) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!arb_vld)                   state_nxt = ST_IDLE;
        else if (len_r[arb_gnt] == '0)  state_nxt = ST_DONE;
        else                            state_nxt = ST_REQ;
      end
      ST_REQ:   if (bus_grant) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_WRITE;
      // Grant is only re-sampled here; single mode goes back through ARB to interleave.
      ST_WRITE: begin
        if (len_dec == '0)                          state_nxt = ST_DONE;
        else if (ctrl_r[cur_ch].burst && bus_grant) state_nxt = ST_READ;
        else                                        state_nxt = ST_ARB;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cur_ch <= '0;
      rr_ptr <= CH_W'(NUM_CH - 1);
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ARB && arb_vld) begin
        cur_ch <= arb_gnt;
        rr_ptr <= arb_gnt;
      end
      if (state == ST_WAIT) data_q <= bus_rdata;
    end
  end

  // The active channel is always armed, so config writes never collide with updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_r  <= '0;
      dst_r  <= '0;
      len_r  <= '0;
      ctrl_r <= '0;
      armed  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && cfg_ch == CH_W'(c) && !armed[c]) begin
          case (cfg_sel)
            SEL_SRC: src_r[c] <= cfg_wdata;
            SEL_DST: dst_r[c] <= cfg_wdata;
            SEL_LEN: len_r[c] <= cfg_wdata[LEN_W-1:0];
            default: begin
              ctrl_r[c] <= dma_ctrl_t'(cfg_wdata[CTRL_DST_FIX:CTRL_BURST]);
              armed[c]  <= cfg_wdata[CTRL_START];
            end
          endcase
        end else if (cur_ch == CH_W'(c)) begin
          if (state == ST_WRITE) begin
            len_r[c] <= len_dec;
            if (!ctrl_r[c].src_fix) src_r[c] <= src_r[c] + ADDR_W'(1);
            if (!ctrl_r[c].dst_fix) dst_r[c] <= dst_r[c] + ADDR_W'(1);
          end
          if (state == ST_DONE) armed[c] <= 1'b0;
        end
      end
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for an edge.
  always_comb begin
    bus_req   = state inside {ST_REQ, ST_READ, ST_WAIT, ST_WRITE};
    bus_rd    = (state == ST_READ);
    bus_wr    = (state == ST_WRITE);
    bus_addr  = '0;
    bus_wdata = '0;
    ch_done   = '0;
    busy      = (state != ST_IDLE);
    if (bus_rd) bus_addr = src_r[cur_ch];
    if (bus_wr) begin
      bus_addr  = dst_r[cur_ch];
      bus_wdata = data_q;
    end
    if (state == ST_DONE) ch_done[cur_ch] = 1'b1;
  end

endmodule
